// File: rtl/tcm_port_arbiter.sv
// Round-robin arbiter sharing one TCM RAM port between instruction-fetch and data requesters.
// Zero-fills the low boot region after reset, then grants one access per cycle with a 1-cycle response.
module tcm_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int CLEAR_WORDS = 16384
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [31:0]           i_addr_i,
  output logic                  i_accept_o,
  output logic                  i_valid_o,
  output logic [31:0]           i_data_o,
  output logic                  i_error_o,
  input  logic                  d_req_i,
  input  logic [31:0]           d_addr_i,
  input  logic [31:0]           d_wdata_i,
  input  logic [3:0]            d_wr_i,
  output logic                  d_accept_o,
  output logic                  d_valid_o,
  output logic [31:0]           d_data_o,
  output logic                  d_error_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [31:0]           ram_data_o,
  output logic [3:0]            ram_wr_o,
  input  logic [31:0]           ram_data_i,
  output logic                  init_done_o
);

  localparam int WAW = ADDR_WIDTH - 2;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam state_t RESET_STATE = (CLEAR_WORDS == 0) ? RUN : CLEAR;
  localparam logic [WAW-1:0] CLR_LAST = WAW'(CLEAR_WORDS - 1);

  state_t state_q, state_d;

  logic [WAW-1:0] clr_cnt_q;
  logic [WAW-1:0] addr_q;
  logic [WAW-1:0] ram_addr_d;
  logic           last_d_q;
  logic           grant_i, grant_d;
  logic           i_in_range, d_in_range;
  logic           i_valid_q, i_err_q;
  logic           d_valid_q, d_err_q, d_rd_q;
  logic           init_done_q;

  assign i_in_range = (i_addr_i >> ADDR_WIDTH) == 32'd0;
  assign d_in_range = (d_addr_i >> ADDR_WIDTH) == 32'd0;

  // The RAM samples its address on the accept cycle, so the grant and address are combinational;
  // addr_q only exists to keep the port address steady on idle cycles.
  always_comb begin
    state_d    = state_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    ram_addr_d = addr_q;
    ram_data_o = d_wdata_i;
    ram_wr_o   = 4'h0;
    case (state_q)
      CLEAR: begin
        ram_addr_d = clr_cnt_q;
        ram_data_o = 32'd0;
        ram_wr_o   = 4'hF;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        grant_d = d_req_i && (!i_req_i || !last_d_q);
        grant_i = i_req_i && !grant_d;
        if (grant_d && d_in_range) begin
          ram_addr_d = d_addr_i[ADDR_WIDTH-1:2];
          ram_wr_o   = d_wr_i;
        end else if (grant_i && i_in_range) begin
          ram_addr_d = i_addr_i[ADDR_WIDTH-1:2];
        end
      end
      default: state_d = RESET_STATE;
    endcase
    if (rst_i) begin
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      ram_wr_o   = 4'h0;
      ram_addr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      addr_q      <= '0;
      last_d_q    <= 1'b0;
      i_valid_q   <= 1'b0;
      i_err_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rd_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= ram_addr_d;
      if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
      if (grant_i || grant_d) begin
        last_d_q <= grant_d;
      end
      i_valid_q   <= grant_i;
      i_err_q     <= grant_i && !i_in_range;
      d_valid_q   <= grant_d;
      d_err_q     <= grant_d && !d_in_range;
      d_rd_q      <= grant_d && (d_wr_i == 4'h0);
      init_done_q <= (state_d == RUN);
    end
  end

  assign i_accept_o  = grant_i;
  assign d_accept_o  = grant_d;
  assign ram_addr_o  = ram_addr_d;
  assign init_done_o = init_done_q;

  // Write responses and errors return zero rather than the read-first old word.
  assign i_valid_o = i_valid_q;
  assign i_error_o = i_err_q;
  assign i_data_o  = (i_valid_q && !i_err_q) ? ram_data_i : 32'd0;
  assign d_valid_o = d_valid_q;
  assign d_error_o = d_err_q;
  assign d_data_o  = (d_valid_q && d_rd_q && !d_err_q) ? ram_data_i : 32'd0;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: directed scenarios plus randomized I/D traffic scored against
// a word-array memory model and the round-robin rule, with a read-first RAM behind the port.
`timescale 1ns/1ps
module tb_tcm_port_arbiter;
  localparam int AW    = 16;
  localparam int CW    = 4;
  localparam int WORDS = 1 << (AW - 2);

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = 32'd0;
  logic        i_accept_o, i_valid_o, i_error_o;
  logic [31:0] i_data_o;
  logic        d_req_i = 1'b0;
  logic [31:0] d_addr_i = 32'd0;
  logic [31:0] d_wdata_i = 32'd0;
  logic [3:0]  d_wr_i = 4'h0;
  logic        d_accept_o, d_valid_o, d_error_o;
  logic [31:0] d_data_o;
  logic [13:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_wr_o;
  logic [31:0] ram_data_i = 32'd0;
  logic        init_done_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram       [0:WORDS-1];
  logic [31:0] model_mem [0:WORDS-1];
  bit          model_last_d = 1'b0;

  tcm_port_arbiter #(.ADDR_WIDTH(AW), .CLEAR_WORDS(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_accept_o(i_accept_o),
    .i_valid_o(i_valid_o), .i_data_o(i_data_o), .i_error_o(i_error_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_wr_i(d_wr_i),
    .d_accept_o(d_accept_o), .d_valid_o(d_valid_o), .d_data_o(d_data_o), .d_error_o(d_error_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
    .ram_data_i(ram_data_i), .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Registered read-first RAM with byte strobes.
  always @(posedge clk_i) begin
    ram_data_i <= ram[ram_addr_o];
    for (int b = 0; b < 4; b++) begin
      if (ram_wr_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  function automatic logic [31:0] init_val(input int k);
    return 32'hC0DE_0000 | k;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) a[16 + $urandom_range(0, 15)] = 1'b1;
    return a;
  endfunction

  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    i_req_i = 1'b1; i_addr_i = 32'h14;
    d_req_i = 1'b1; d_addr_i = 32'h14; d_wr_i = 4'h0; d_wdata_i = 32'd0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (init_done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done_o); end
    checks++; if (ram_wr_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_ram_wr: got %h expected 0", ram_wr_o); end
    checks++; if ({i_valid_o, d_valid_o, i_error_o, d_error_o} !== 4'b0) begin errors++; $display("[TB] FAIL reset_valid_err: got %b expected 0000", {i_valid_o, d_valid_o, i_error_o, d_error_o}); end
    checks++; if ({i_accept_o, d_accept_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_accept: got %b expected 00", {i_accept_o, d_accept_o}); end
    next_cycle();
    rst_i = 1'b0;
    for (int k = 0; k < CW; k++) begin
      @(negedge clk_i);
      checks++; if (ram_wr_o !== 4'hF) begin errors++; $display("[TB] FAIL clear_wr[%0d]: got %h expected f", k, ram_wr_o); end
      checks++; if (ram_addr_o !== 14'(k)) begin errors++; $display("[TB] FAIL clear_addr[%0d]: got %h expected %h", k, ram_addr_o, 14'(k)); end
      checks++; if (ram_data_o !== 32'd0) begin errors++; $display("[TB] FAIL clear_data[%0d]: got %h expected 0", k, ram_data_o); end
      checks++; if ({i_accept_o, d_accept_o, init_done_o} !== 3'b000) begin errors++; $display("[TB] FAIL clear_holdoff[%0d]: got %b expected 000", k, {i_accept_o, d_accept_o, init_done_o}); end
      next_cycle();
    end
    @(negedge clk_i);
    checks++; if (init_done_o !== 1'b1) begin errors++; $display("[TB] FAIL init_done_cycle5: got %b expected 1", init_done_o); end
    checks++; if ({i_accept_o, d_accept_o} !== 2'b01) begin errors++; $display("[TB] FAIL first_tie_d_wins: got %b expected 01", {i_accept_o, d_accept_o}); end
    next_cycle();
    i_req_i = 1'b0; d_req_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({i_valid_o, d_valid_o} !== 2'b01) begin errors++; $display("[TB] FAIL first_resp_valid: got %b expected 01", {i_valid_o, d_valid_o}); end
    checks++; if (d_data_o !== init_val(5)) begin errors++; $display("[TB] FAIL first_resp_data: got %h expected %h", d_data_o, init_val(5)); end
    for (int k = 0; k < CW; k++) model_mem[k] = 32'd0;
    model_last_d = 1'b1;
    next_cycle();
  endtask

  task automatic test_alternate;
    bit prev_i;
    bit exp_i;
    prev_i = 1'b0;
    i_req_i = 1'b1; i_addr_i = 32'h18;
    d_req_i = 1'b1; d_addr_i = 32'h1C; d_wr_i = 4'h0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 6) begin i_req_i = 1'b0; d_req_i = 1'b0; end
      @(negedge clk_i);
      if (c < 6) begin
        exp_i = (c % 2 == 0);
        checks++; if ({i_accept_o, d_accept_o} !== {exp_i, !exp_i}) begin errors++; $display("[TB] FAIL alt_accept[%0d]: got %b expected %b", c, {i_accept_o, d_accept_o}, {exp_i, !exp_i}); end
      end
      if (c > 0) begin
        checks++; if ({i_valid_o, d_valid_o} !== {prev_i, !prev_i}) begin errors++; $display("[TB] FAIL alt_valid[%0d]: got %b expected %b", c, {i_valid_o, d_valid_o}, {prev_i, !prev_i}); end
        if (prev_i) begin
          checks++; if (i_data_o !== model_mem[6]) begin errors++; $display("[TB] FAIL alt_i_data[%0d]: got %h expected %h", c, i_data_o, model_mem[6]); end
        end else begin
          checks++; if (d_data_o !== model_mem[7]) begin errors++; $display("[TB] FAIL alt_d_data[%0d]: got %h expected %h", c, d_data_o, model_mem[7]); end
        end
      end
      prev_i = (c % 2 == 0);
      next_cycle();
    end
    model_last_d = 1'b1;
  endtask

  task automatic test_write_read;
    d_req_i = 1'b1; d_addr_i = 32'h400; d_wdata_i = 32'h1122_3344; d_wr_i = 4'b0101;
    @(negedge clk_i);
    checks++; if (d_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_accept: got %b expected 1", d_accept_o); end
    checks++; if (ram_wr_o !== 4'b0101) begin errors++; $display("[TB] FAIL wr_strobes: got %b expected 0101", ram_wr_o); end
    checks++; if (ram_addr_o !== 14'h100) begin errors++; $display("[TB] FAIL wr_addr: got %h expected 100", ram_addr_o); end
    checks++; if (ram_data_o !== 32'h1122_3344) begin errors++; $display("[TB] FAIL wr_data: got %h expected 11223344", ram_data_o); end
    next_cycle();
    d_req_i = 1'b0; d_wr_i = 4'h0;
    i_req_i = 1'b1; i_addr_i = 32'h400;
    @(negedge clk_i);
    checks++; if (i_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL rd_accept: got %b expected 1", i_accept_o); end
    checks++; if ({d_valid_o, d_error_o} !== 2'b10) begin errors++; $display("[TB] FAIL wr_resp: got %b expected 10", {d_valid_o, d_error_o}); end
    checks++; if (d_data_o !== 32'd0) begin errors++; $display("[TB] FAIL wr_resp_data: got %h expected 0", d_data_o); end
    next_cycle();
    i_req_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({i_valid_o, i_error_o} !== 2'b10) begin errors++; $display("[TB] FAIL rd_resp: got %b expected 10", {i_valid_o, i_error_o}); end
    checks++; if (i_data_o !== 32'hAA22_CC44) begin errors++; $display("[TB] FAIL rd_merged_data: got %h expected aa22cc44", i_data_o); end
    model_mem[14'h100] = 32'hAA22_CC44;
    model_last_d = 1'b0;
    next_cycle();
  endtask

  task automatic test_out_of_range;
    d_req_i = 1'b1; d_addr_i = 32'h0001_0000; d_wr_i = 4'h0;
    @(negedge clk_i);
    checks++; if (d_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL oor_rd_accept: got %b expected 1", d_accept_o); end
    checks++; if (ram_wr_o !== 4'h0) begin errors++; $display("[TB] FAIL oor_rd_wr: got %h expected 0", ram_wr_o); end
    next_cycle();
    d_addr_i = 32'h0001_0004; d_wr_i = 4'hF; d_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    checks++; if ({d_valid_o, d_error_o} !== 2'b11) begin errors++; $display("[TB] FAIL oor_rd_resp: got %b expected 11", {d_valid_o, d_error_o}); end
    checks++; if (d_data_o !== 32'd0) begin errors++; $display("[TB] FAIL oor_rd_data: got %h expected 0", d_data_o); end
    checks++; if (ram_wr_o !== 4'h0) begin errors++; $display("[TB] FAIL oor_wr_blocked: got %h expected 0", ram_wr_o); end
    next_cycle();
    d_req_i = 1'b0; d_wr_i = 4'h0;
    @(negedge clk_i);
    checks++; if ({d_valid_o, d_error_o} !== 2'b11) begin errors++; $display("[TB] FAIL oor_wr_resp: got %b expected 11", {d_valid_o, d_error_o}); end
    model_last_d = 1'b1;
    next_cycle();
  endtask

  task automatic test_i_stream;
    logic [31:0] addrs [4];
    addrs = '{32'h400, 32'h20, 32'h24, 32'h28};
    for (int c = 0; c <= 5; c++) begin
      if (c < 4) begin i_req_i = 1'b1; i_addr_i = addrs[c]; end
      else i_req_i = 1'b0;
      @(negedge clk_i);
      if (c < 4) begin
        checks++; if (i_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL stream_accept[%0d]: got %b expected 1", c, i_accept_o); end
      end
      if (c > 0 && c < 5) begin
        checks++; if (i_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", c, i_valid_o); end
        checks++; if (i_data_o !== model_mem[addrs[c-1][15:2]]) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", c, i_data_o, model_mem[addrs[c-1][15:2]]); end
      end
      if (c == 5) begin
        checks++; if (i_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL stream_valid_end: got %b expected 0", i_valid_o); end
      end
      next_cycle();
    end
    model_last_d = 1'b0;
  endtask

  task automatic test_random(input int n);
    bit i_hold, d_hold, exp_ia, exp_da, oi, od;
    bit pv_i, pv_d, pe_i, pe_d;
    logic [31:0] pd_i, pd_d;
    logic [3:0] exp_wr;
    int wi, wd;
    i_hold = 0; d_hold = 0; pv_i = 0; pv_d = 0; pe_i = 0; pe_d = 0; pd_i = 0; pd_d = 0;
    for (int c = 0; c <= n; c++) begin
      if (c == n) begin
        i_req_i = 1'b0; d_req_i = 1'b0;
      end else begin
        if (!i_hold) begin i_req_i = 1'($urandom_range(0, 1)); i_addr_i = rand_addr(); end
        if (!d_hold) begin
          d_req_i = 1'($urandom_range(0, 1)); d_addr_i = rand_addr(); d_wdata_i = $urandom;
          d_wr_i = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
      end
      @(negedge clk_i);
      checks++; if ({i_valid_o, d_valid_o} !== {pv_i, pv_d}) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", c, {i_valid_o, d_valid_o}, {pv_i, pv_d}); end
      if (pv_i) begin
        checks++; if ({i_error_o, i_data_o} !== {pe_i, pd_i}) begin errors++; $display("[TB] FAIL rnd_i_resp[%0d]: got err=%b data=%h expected err=%b data=%h", c, i_error_o, i_data_o, pe_i, pd_i); end
      end
      if (pv_d) begin
        checks++; if ({d_error_o, d_data_o} !== {pe_d, pd_d}) begin errors++; $display("[TB] FAIL rnd_d_resp[%0d]: got err=%b data=%h expected err=%b data=%h", c, d_error_o, d_data_o, pe_d, pd_d); end
      end
      exp_da = d_req_i && (!i_req_i || !model_last_d);
      exp_ia = i_req_i && !exp_da;
      oi = (i_addr_i[31:AW] != 0);
      od = (d_addr_i[31:AW] != 0);
      wi = int'(i_addr_i[AW-1:2]);
      wd = int'(d_addr_i[AW-1:2]);
      exp_wr = (exp_da && !od) ? d_wr_i : 4'h0;
      checks++; if ({i_accept_o, d_accept_o} !== {exp_ia, exp_da}) begin errors++; $display("[TB] FAIL rnd_accept[%0d]: got %b expected %b", c, {i_accept_o, d_accept_o}, {exp_ia, exp_da}); end
      checks++; if (ram_wr_o !== exp_wr) begin errors++; $display("[TB] FAIL rnd_ram_wr[%0d]: got %h expected %h", c, ram_wr_o, exp_wr); end
      if ((exp_da && !od) || (exp_ia && !oi)) begin
        checks++; if (ram_addr_o !== 14'(exp_da ? wd : wi)) begin errors++; $display("[TB] FAIL rnd_ram_addr[%0d]: got %h expected %h", c, ram_addr_o, 14'(exp_da ? wd : wi)); end
      end
      pv_i = exp_ia; pe_i = exp_ia && oi; pd_i = (exp_ia && !oi) ? model_mem[wi] : 32'd0;
      pv_d = exp_da; pe_d = exp_da && od; pd_d = (exp_da && !od && d_wr_i == 4'h0) ? model_mem[wd] : 32'd0;
      if (exp_da && !od) begin
        for (int b = 0; b < 4; b++) if (d_wr_i[b]) model_mem[wd][8*b +: 8] = d_wdata_i[8*b +: 8];
      end
      if (exp_ia || exp_da) model_last_d = exp_da;
      i_hold = i_req_i && !exp_ia;
      d_hold = d_req_i && !exp_da;
      next_cycle();
    end
    d_wr_i = 4'h0;
  endtask

  task automatic test_mid_reset;
    i_req_i = 1'b1; i_addr_i = 32'h20;
    @(negedge clk_i);
    checks++; if (i_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL mr_accept: got %b expected 1", i_accept_o); end
    next_cycle();
    i_req_i = 1'b0;
    checks++; if (i_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL mr_pending: got %b expected 1", i_valid_o); end
    rst_i = 1'b1;
    #1;
    checks++; if ({i_valid_o, init_done_o, ram_wr_o} !== 6'd0) begin errors++; $display("[TB] FAIL mr_drop: got %b expected 000000", {i_valid_o, init_done_o, ram_wr_o}); end
    next_cycle();
    rst_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checks++; if ({ram_wr_o, ram_addr_o} !== {4'hF, 14'(k)}) begin errors++; $display("[TB] FAIL mr_clear1[%0d]: got wr=%h addr=%h expected wr=f addr=%h", k, ram_wr_o, ram_addr_o, 14'(k)); end
      next_cycle();
    end
    rst_i = 1'b1;
    #1;
    checks++; if (ram_wr_o !== 4'h0) begin errors++; $display("[TB] FAIL mr_clear_reset_wr: got %h expected 0", ram_wr_o); end
    next_cycle();
    rst_i = 1'b0;
    for (int k = 0; k < CW; k++) begin
      @(negedge clk_i);
      checks++; if ({ram_wr_o, ram_addr_o, init_done_o} !== {4'hF, 14'(k), 1'b0}) begin errors++; $display("[TB] FAIL mr_clear2[%0d]: got wr=%h addr=%h done=%b expected wr=f addr=%h done=0", k, ram_wr_o, ram_addr_o, init_done_o, 14'(k)); end
      next_cycle();
    end
    @(negedge clk_i);
    checks++; if (init_done_o !== 1'b1) begin errors++; $display("[TB] FAIL mr_init_done: got %b expected 1", init_done_o); end
    for (int k = 0; k < CW; k++) model_mem[k] = 32'd0;
    model_last_d = 1'b0;
    next_cycle();
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      ram[k] = init_val(k);
      model_mem[k] = init_val(k);
    end
    ram[14'h100] = 32'hAABB_CCDD;
    model_mem[14'h100] = 32'hAABB_CCDD;
    #1;
    test_reset();
    test_alternate();
    test_write_read();
    test_out_of_range();
    test_i_stream();
    test_random(400);
    test_mid_reset();
    test_random(150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
